// File: rtl/dump_pkg.sv
// Shared definitions for the DRAM dump path: default memory geometry that
// matches the processor's external memory port, and the dump FSM encoding.
package dump_pkg;

  // Default external memory port geometry, kept in step with top_control.
  localparam int DUMP_ADDR_W = 9;
  localparam int DUMP_DATA_W = 16;

  // Dump sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_e;

endpackage

// File: rtl/dump_lat_ctr.sv
// Read-latency down-counter. Loaded while a read strobe is on the bus and
// flags the cycle in which the memory's read data becomes valid. The flag is
// only meaningful while the controller is waiting on a read it issued.
module dump_lat_ctr #(
  parameter int READ_LAT = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_load,
  output logic o_rdata_valid
);

  // READ_LAT ranges 1..4, so a 2-bit counter holds READ_LAT-1.
  localparam logic [1:0] LOAD_VAL = 2'(READ_LAT - 1);

  logic [1:0] r_cnt;

  // Load on the strobe cycle, then count down and rest at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 2'd0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != 2'd0) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  assign o_rdata_valid = (r_cnt == 2'd0);

endmodule

// File: rtl/dram_dump_ctrl.sv
// DRAM dump controller: after the processor halts, reads an inclusive address
// range through the external memory port one word at a time and streams each
// word, tagged with its address, to a valid/ready sink. At most one read is in
// flight and no new read is issued while a word waits for the sink.
module dram_dump_ctrl
  import dump_pkg::*;
#(
  parameter int ADDR_W   = DUMP_ADDR_W,
  parameter int DATA_W   = DUMP_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] mem_addr_ext,
  output logic              mem_read_ext,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  dump_state_e       r_state;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_lim;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_read;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_range_err;
  logic [ADDR_W:0]   r_word_count;

  logic              w_lat_load;
  logic              w_rdata_valid;

  // The latency counter is armed during the single strobe cycle.
  assign w_lat_load = (r_state == ST_ISSUE);

  dump_lat_ctr #(
    .READ_LAT (READ_LAT)
  ) u_lat_ctr (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_load        (w_lat_load),
    .o_rdata_valid (w_rdata_valid)
  );

  // Dump sequencer; every output is a register so the strobe and the
  // handshake signals are glitch-free and change only at clock edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cur        <= '0;
      r_lim        <= '0;
      r_mem_addr   <= '0;
      r_mem_read   <= 1'b0;
      r_out_data   <= '0;
      r_out_addr   <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_range_err  <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_mem_read  <= 1'b0;
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (dump_start) begin
            r_word_count <= '0;
            if (first_addr <= last_addr) begin
              r_cur      <= first_addr;
              r_lim      <= last_addr;
              r_busy     <= 1'b1;
              r_mem_read <= 1'b1;
              r_mem_addr <= first_addr;
              r_state    <= ST_ISSUE;
            end else begin
              r_range_err <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_rdata_valid) begin
            r_out_data  <= mem_rdata;
            r_out_addr  <= r_cur;
            r_out_valid <= 1'b1;
            r_state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_word_count <= r_word_count + COUNT_ONE;
            // Compare before incrementing so a range ending at the top
            // address never wraps back to zero.
            if (r_cur == r_lim) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_cur      <= r_cur + ADDR_ONE;
              r_mem_addr <= r_cur + ADDR_ONE;
              r_mem_read <= 1'b1;
              r_state    <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr_ext = r_mem_addr;
  assign mem_read_ext = r_mem_read;
  assign out_data     = r_out_data;
  assign out_addr     = r_out_addr;
  assign out_valid    = r_out_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign range_err    = r_range_err;
  assign word_count   = r_word_count;

endmodule

// File: tb/tb_dram_dump_ctrl.sv
// Directed bench for dram_dump_ctrl. Two instances share one memory image:
// one built with a single-cycle read latency, one with a three-cycle latency.
module tb_dram_dump_ctrl;

  logic        clock;
  logic        reset_n;
  logic        dumpStart;
  logic        useDut3;
  logic [8:0]  firstAddr;
  logic [8:0]  lastAddr;
  logic        outReady;

  logic [15:0] mem [0:511];

  logic [8:0]  memAddr1, memAddr3, outAddr1, outAddr3;
  logic        memRead1, memRead3, outValid1, outValid3;
  logic [15:0] memRdata1, memRdata3, outData1, outData3;
  logic        busy1, busy3, done1, done3, rangeErr1, rangeErr3;
  logic [9:0]  wordCount1, wordCount3;

  logic        dumpStart1, dumpStart3;
  logic [8:0]  pipeAddrA, pipeAddrB;
  logic        pipeVldA, pipeVldB;

  logic        selValid, selRead, selBusy, selDone;
  logic [8:0]  selAddr, selMemAddr;
  logic [15:0] selData;
  logic [9:0]  selCount;

  int assertCount = 0;
  int failCount   = 0;
  int n;

  // Start pulses are steered to whichever instance is under test.
  assign dumpStart1 = dumpStart & ~useDut3;
  assign dumpStart3 = dumpStart &  useDut3;

  dram_dump_ctrl #(.ADDR_W(9), .DATA_W(16), .READ_LAT(1)) u_dut1 (
    .clock        (clock),
    .reset_n      (reset_n),
    .dump_start   (dumpStart1),
    .first_addr   (firstAddr),
    .last_addr    (lastAddr),
    .mem_addr_ext (memAddr1),
    .mem_read_ext (memRead1),
    .mem_rdata    (memRdata1),
    .out_data     (outData1),
    .out_addr     (outAddr1),
    .out_valid    (outValid1),
    .out_ready    (outReady),
    .busy         (busy1),
    .done         (done1),
    .range_err    (rangeErr1),
    .word_count   (wordCount1)
  );

  dram_dump_ctrl #(.ADDR_W(9), .DATA_W(16), .READ_LAT(3)) u_dut3 (
    .clock        (clock),
    .reset_n      (reset_n),
    .dump_start   (dumpStart3),
    .first_addr   (firstAddr),
    .last_addr    (lastAddr),
    .mem_addr_ext (memAddr3),
    .mem_read_ext (memRead3),
    .mem_rdata    (memRdata3),
    .out_data     (outData3),
    .out_addr     (outAddr3),
    .out_valid    (outValid3),
    .out_ready    (outReady),
    .busy         (busy3),
    .done         (done3),
    .range_err    (rangeErr3),
    .word_count   (wordCount3)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-cycle memory: data is valid only in the cycle after the strobe,
  // otherwise a poison value is driven so a mistimed capture is visible.
  always @(posedge clock) begin
    memRdata1 <= memRead1 ? mem[memAddr1] : 16'hDEAD;
  end

  // Three-cycle memory: the strobe travels through two pipeline stages and
  // the data is driven for exactly one cycle, three edges after the strobe.
  always @(posedge clock) begin
    pipeVldA  <= memRead3;
    pipeAddrA <= memAddr3;
    pipeVldB  <= pipeVldA;
    pipeAddrB <= pipeAddrA;
    memRdata3 <= pipeVldB ? mem[pipeAddrB] : 16'hDEAD;
  end

  // Observe the instance currently under test through one set of names.
  always_comb begin
    selValid   = useDut3 ? outValid3  : outValid1;
    selRead    = useDut3 ? memRead3   : memRead1;
    selBusy    = useDut3 ? busy3      : busy1;
    selDone    = useDut3 ? done3      : done1;
    selAddr    = useDut3 ? outAddr3   : outAddr1;
    selMemAddr = useDut3 ? memAddr3   : memAddr1;
    selData    = useDut3 ? outData3   : outData1;
    selCount   = useDut3 ? wordCount3 : wordCount1;
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One comparison point: counted, asserted, reported on failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse dump_start for one clock with the given range.
  task automatic applyStimulus(input logic [8:0] first, input logic [8:0] last);
    firstAddr = first;
    lastAddr  = last;
    dumpStart = 1'b1;
    tick();
    dumpStart = 1'b0;
  endtask

  // Clock until out_valid rises (bounded); n counts the clocks taken.
  task automatic waitValid(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!selValid && cycles < 40);
    checkOutput("valid_seen", 32'(selValid), 32'd1);
  endtask

  // Safety net in case a bounded loop is somehow bypassed.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    reset_n   = 1'b0;
    dumpStart = 1'b0;
    useDut3   = 1'b0;
    firstAddr = '0;
    lastAddr  = '0;
    outReady  = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = 16'(i) ^ 16'h5A00;
    mem[0]   = 16'h00AA;
    mem[1]   = 16'd10;
    mem[2]   = 16'd20;
    mem[3]   = 16'd30;
    mem[4]   = 16'd40;
    mem[511] = 16'hBEEF;

    // Reset values
    tick();
    tick();
    checkOutput("rst_valid", 32'(outValid1), 32'd0);
    checkOutput("rst_busy", 32'(busy1), 32'd0);
    checkOutput("rst_done", 32'(done1), 32'd0);
    checkOutput("rst_rangeerr", 32'(rangeErr1), 32'd0);
    checkOutput("rst_read", 32'(memRead1), 32'd0);
    checkOutput("rst_memaddr", 32'(memAddr1), 32'd0);
    checkOutput("rst_count", 32'(wordCount1), 32'd0);
    reset_n = 1'b1;
    tick();

    // Test 1: four words, sink always ready
    $display("[TB] test 1: range 1..4 streaming");
    applyStimulus(9'd1, 9'd4);
    checkOutput("t1_busy", 32'(selBusy), 32'd1);
    checkOutput("t1_read", 32'(selRead), 32'd1);
    checkOutput("t1_memaddr", 32'(selMemAddr), 32'd1);
    for (int w = 1; w <= 4; w++) begin
      waitValid(n);
      checkOutput("t1_gap", 32'(n), (w == 1) ? 32'd2 : 32'd3);
      checkOutput("t1_addr", 32'(selAddr), 32'(w));
      checkOutput("t1_data", 32'(selData), 32'(w * 10));
    end
    tick();
    checkOutput("t1_done", 32'(selDone), 32'd1);
    checkOutput("t1_busy_fall", 32'(selBusy), 32'd0);
    checkOutput("t1_count", 32'(selCount), 32'd4);
    checkOutput("t1_valid_low", 32'(selValid), 32'd0);
    tick();
    checkOutput("t1_done_once", 32'(selDone), 32'd0);

    // Test 2: sink stalls five cycles on the second word
    $display("[TB] test 2: stall on word 2");
    applyStimulus(9'd1, 9'd4);
    waitValid(n);
    checkOutput("t2_w1_addr", 32'(selAddr), 32'd1);
    checkOutput("t2_w1_data", 32'(selData), 32'd10);
    waitValid(n);
    outReady = 1'b0;
    checkOutput("t2_w2_gap", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t2_stall_valid", 32'(selValid), 32'd1);
      checkOutput("t2_stall_addr", 32'(selAddr), 32'd2);
      checkOutput("t2_stall_data", 32'(selData), 32'd20);
      checkOutput("t2_stall_read", 32'(selRead), 32'd0);
    end
    outReady = 1'b1;
    for (int w = 3; w <= 4; w++) begin
      waitValid(n);
      checkOutput("t2_gap", 32'(n), 32'd3);
      checkOutput("t2_addr", 32'(selAddr), 32'(w));
      checkOutput("t2_data", 32'(selData), 32'(w * 10));
    end
    tick();
    checkOutput("t2_done", 32'(selDone), 32'd1);
    checkOutput("t2_count", 32'(selCount), 32'd4);
    tick();

    // Test 3: inverted range
    $display("[TB] test 3: first > last");
    applyStimulus(9'd7, 9'd3);
    checkOutput("t3_rangeerr", 32'(rangeErr1), 32'd1);
    checkOutput("t3_read", 32'(selRead), 32'd0);
    checkOutput("t3_busy", 32'(selBusy), 32'd0);
    checkOutput("t3_count", 32'(selCount), 32'd0);
    checkOutput("t3_done", 32'(selDone), 32'd0);
    tick();
    checkOutput("t3_rangeerr_pulse", 32'(rangeErr1), 32'd0);
    checkOutput("t3_read2", 32'(selRead), 32'd0);
    checkOutput("t3_done2", 32'(selDone), 32'd0);

    // Test 4: single word at the top address
    $display("[TB] test 4: single word at 0x1FF");
    applyStimulus(9'h1FF, 9'h1FF);
    checkOutput("t4_memaddr", 32'(selMemAddr), 32'h1FF);
    waitValid(n);
    checkOutput("t4_gap", 32'(n), 32'd2);
    checkOutput("t4_addr", 32'(selAddr), 32'h1FF);
    checkOutput("t4_data", 32'(selData), 32'hBEEF);
    tick();
    checkOutput("t4_done", 32'(selDone), 32'd1);
    checkOutput("t4_count", 32'(selCount), 32'd1);
    checkOutput("t4_memaddr_hold", 32'(selMemAddr), 32'h1FF);
    checkOutput("t4_read", 32'(selRead), 32'd0);
    tick();
    checkOutput("t4_busy", 32'(selBusy), 32'd0);
    checkOutput("t4_memaddr_idle", 32'(selMemAddr), 32'h1FF);

    // Test 5: three-cycle read latency, range 0..1
    $display("[TB] test 5: READ_LAT=3");
    useDut3 = 1'b1;
    applyStimulus(9'd0, 9'd1);
    checkOutput("t5_read", 32'(selRead), 32'd1);
    checkOutput("t5_memaddr", 32'(selMemAddr), 32'd0);
    waitValid(n);
    checkOutput("t5_gap1", 32'(n), 32'd4);
    checkOutput("t5_addr1", 32'(selAddr), 32'd0);
    checkOutput("t5_data1", 32'(selData), 32'h00AA);
    waitValid(n);
    checkOutput("t5_gap2", 32'(n), 32'd5);
    checkOutput("t5_addr2", 32'(selAddr), 32'd1);
    checkOutput("t5_data2", 32'(selData), 32'd10);
    tick();
    checkOutput("t5_done", 32'(selDone), 32'd1);
    checkOutput("t5_count", 32'(selCount), 32'd2);
    tick();
    useDut3 = 1'b0;

    // Test 6: reset during the second word's presentation
    $display("[TB] test 6: reset mid-dump");
    applyStimulus(9'd1, 9'd4);
    waitValid(n);
    waitValid(n);
    outReady = 1'b0;
    checkOutput("t6_pre_addr", 32'(selAddr), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(outValid1), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy1), 32'd0);
    checkOutput("t6_rst_data", 32'(outData1), 32'd0);
    checkOutput("t6_rst_addr", 32'(outAddr1), 32'd0);
    checkOutput("t6_rst_memaddr", 32'(memAddr1), 32'd0);
    checkOutput("t6_rst_count", 32'(wordCount1), 32'd0);
    checkOutput("t6_rst_done", 32'(done1), 32'd0);
    tick();
    reset_n  = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t6_no_done", 32'(done1), 32'd0);
    end
    applyStimulus(9'd0, 9'd0);
    waitValid(n);
    checkOutput("t6_new_gap", 32'(n), 32'd2);
    checkOutput("t6_new_addr", 32'(selAddr), 32'd0);
    checkOutput("t6_new_data", 32'(selData), 32'h00AA);
    tick();
    checkOutput("t6_new_done", 32'(selDone), 32'd1);
    checkOutput("t6_new_count", 32'(selCount), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/dram_dump_ctrl.md
Name: dram_dump_ctrl

Overview:
- Read-side counterpart of the external IRAM/DRAM load path.
- After the processor halts (start deasserted), it walks a DRAM address range through the external memory port and streams each word out on a valid/ready handshake, tagged with its address.
- Sits between top_control's external memory port and a host-facing sink (UART bridge or testbench monitor).

Parameters:
ADDR_W, 9, external memory address width (matches addr_ext)
DATA_W, 16, memory word width
READ_LAT, 1, cycles from mem_read_ext/mem_addr_ext sampled to mem_rdata valid (1..4)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
dump_start  in  1  single-cycle pulse; starts a dump when idle
first_addr  in  ADDR_W  first address to read; sampled on accepted dump_start
last_addr  in  ADDR_W  last address to read, inclusive; sampled with first_addr
mem_addr_ext  out  ADDR_W  external read address to memory
mem_read_ext  out  1  external read strobe, one cycle per word
mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after strobe
out_data  out  DATA_W  streamed word
out_addr  out  ADDR_W  address the out_data word was read from
out_valid  out  1  out_data/out_addr valid
out_ready  in  1  sink accepts the word when out_valid && out_ready at a rising edge
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse when the dump completes
range_err  out  1  one-cycle pulse when first_addr > last_addr (no reads issued)
word_count  out  ADDR_W+1  words delivered in current/last dump; cleared on accepted start

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; word_count 0. Reset may assert mid-dump: every operation aborts immediately, with no done pulse.
- FSM states:
  - IDLE: dump_start is accepted only here and ignored elsewhere.
    - On start with first_addr <= last_addr: cur <= first_addr, lim <= last_addr, word_count <= 0, busy <= 1, go to ISSUE.
    - On start with first_addr > last_addr: pulse range_err for one cycle, busy stays 0, stay IDLE.
  - ISSUE: mem_read_ext = 1 and mem_addr_ext = cur for exactly one cycle. Load latency counter with READ_LAT-1, go to WAIT.
  - WAIT: count down. When mem_rdata is valid, capture it into the out_data register and cur into out_addr, set out_valid, go to PRESENT.
    - With READ_LAT=1, WAIT lasts one cycle: capture in the cycle after ISSUE.
  - PRESENT: hold out_valid, out_data and out_addr stable until out_ready.
    - On handshake: out_valid <= 0, word_count++.
    - If cur == lim, go to DONE. Otherwise cur <= cur+1 and go to ISSUE.
  - DONE: done = 1 for one cycle, busy <= 0, go to IDLE.
- Throughput: one word per (READ_LAT+2) cycles with out_ready held high.
- mem_addr_ext holds the last issued address when not reading; it is 0 after reset.
- Wrap-around: last_addr = 2^ADDR_W-1 is legal. cur == lim is checked before increment, so no wrap occurs.
- Single-address dump (first == last) yields exactly one word, then done.
- out_ready asserted while out_valid = 0 has no effect.
- out_valid never deasserts without a handshake, except on reset.
- mem_read_ext is never asserted while out_valid is high; at most one read is outstanding.

Decomposition:
- Shared package/header dump_pkg:
  - state encodings IDLE/ISSUE/WAIT/PRESENT/DONE (3-bit)
  - default ADDR_W/DATA_W constants shared with top_control's external port
- Sub-module: dump_lat_ctr. A small down-counter producing rdata_valid READ_LAT cycles after a load. Everything else lives in dram_dump_ctrl.

Test Plan:
1. Preload DRAM[1..4] = 16'd10, 20, 30, 40; dump_start with first=1, last=4, out_ready=1.
   - Required: out_addr/out_data pairs (1,10), (2,20), (3,30), (4,40), each 3 cycles apart.
   - Required: done pulses once, word_count = 4, busy falls with done.
2. Same range with out_ready low for 5 cycles on the second word.
   - Required: out_valid held, (2,20) stable throughout.
   - Required: no mem_read_ext asserted during the stall; sequence otherwise identical.
3. first=7, last=3.
   - Required: range_err pulse the next cycle, no mem_read_ext, busy = 0, word_count = 0, no done.
4. first=last=9'h1FF with DRAM[511] = 16'hBEEF.
   - Required: exactly one word (511, BEEF), then done; mem_addr_ext never reaches 0.
5. READ_LAT=3 build, first=0, last=1.
   - Required: data captured 3 cycles after each strobe; one word every 5 cycles.
6. Assert reset_n low during PRESENT of word 2 of 4.
   - Required: all outputs 0 asynchronously, no done pulse.
   - Required: after release, a new dump_start (first=0, last=0) completes normally.
